// File: rtl/cdf_lut_mapper_if.sv
// CDF RAM read port and LUT RAM write port used by the CDF-to-LUT mapper.
// master: the mapper (issues reads, writes LUT); slave: the RAM side.
interface cdf_lut_mapper_if #(
  parameter int ADDR_W = 8,
  parameter int CDF_W  = 20,
  parameter int OUT_W  = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CDF_W-1:0]  rd_data;
  logic              lut_we;
  logic [ADDR_W-1:0] lut_addr;
  logic [OUT_W-1:0]  lut_data;

  modport master (
    output rd_en, rd_addr, lut_we, lut_addr, lut_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, lut_we, lut_addr, lut_data,
    output rd_data
  );
endinterface

// File: rtl/cdf_lut_mapper.sv
// CDF-to-LUT mapper: walks every CDF bin, computes
// round((cdf - cdf_min) * 255 / (pixel_total - cdf_min)) with a restoring
// divider (one quotient bit per cycle) and writes the result into LUT RAM.
module cdf_lut_mapper #(
  parameter int ADDR_W = 8,
  parameter int CDF_W  = 20,
  parameter int OUT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CDF_W-1:0]     cdf_min,
  input  logic [CDF_W-1:0]     pixel_total,
  cdf_lut_mapper_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic                 degenerate
);

  localparam int NUM_W = CDF_W + OUT_W;
  localparam int CNT_W = $clog2(OUT_W + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LD   = 3'd2,
    DIV  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] bin_q, bin_d;
  logic [CDF_W-1:0]  cmin_q, cmin_d;
  logic [CDF_W-1:0]  ptot_q, ptot_d;
  logic [CDF_W-1:0]  den_q, den_d;
  logic [CDF_W-1:0]  rem_q, rem_d;      // partial remainder, always < den
  logic [OUT_W-1:0]  quo_q, quo_d;      // low dividend bits shift out, quotient bits shift in
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  result_q, result_d;

  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              lut_we_q, lut_we_d;
  logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
  logic [OUT_W-1:0]  lut_data_q, lut_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              degen_q, degen_d;

  logic [CDF_W:0]    trial_s;
  logic [CDF_W-1:0]  diff_s;
  logic [NUM_W-1:0]  diff_ext_s;
  logic [NUM_W-1:0]  num_s;

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    cmin_d   = cmin_q;
    ptot_d   = ptot_q;
    den_d    = den_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    degen_d  = degen_q;

    trial_s    = {rem_q, quo_q[OUT_W-1]};
    diff_s     = bus.rd_data - cmin_q;
    diff_ext_s = NUM_W'(diff_s);
    // diff*255 + den/2, rounding half-up once divided by den
    num_s      = (diff_ext_s << OUT_W) - diff_ext_s + NUM_W'(den_q >> 1);

    case (state_q)
      IDLE: begin
        if (start) begin
          cmin_d = cdf_min;
          ptot_d = pixel_total;
          if (pixel_total <= cdf_min) begin
            den_d   = {CDF_W{1'b0}};
            degen_d = 1'b1;
          end else begin
            den_d   = pixel_total - cdf_min;
            degen_d = 1'b0;
          end
          bin_d   = {ADDR_W{1'b0}};
          state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        state_d = LD;
      end
      LD: begin
        if (den_q == {CDF_W{1'b0}}) begin
          result_d = OUT_W'(bin_q);
          state_d  = WR;
        end else if (bus.rd_data <= cmin_q) begin
          result_d = {OUT_W{1'b0}};
          state_d  = WR;
        end else if (bus.rd_data >= ptot_q) begin
          result_d = {OUT_W{1'b1}};
          state_d  = WR;
        end else begin
          // num < 256*den, so the top CDF_W bits already form a remainder < den
          rem_d   = num_s[NUM_W-1:OUT_W];
          quo_d   = num_s[OUT_W-1:0];
          cnt_d   = {CNT_W{1'b0}};
          state_d = DIV;
        end
      end
      DIV: begin
        if (trial_s >= {1'b0, den_q}) begin
          rem_d = CDF_W'(trial_s - {1'b0, den_q});
          quo_d = {quo_q[OUT_W-2:0], 1'b1};
        end else begin
          rem_d = trial_s[CDF_W-1:0];
          quo_d = {quo_q[OUT_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OUT_W - 1)) begin
          result_d = quo_d;
          state_d  = WR;
        end else begin
          state_d  = DIV;
        end
      end
      WR: begin
        if (bin_q == {ADDR_W{1'b1}}) begin
          state_d = DONE;
        end else begin
          bin_d   = bin_q + ADDR_W'(1);
          state_d = RD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    rd_en_d    = (state_d == RD);
    rd_addr_d  = (state_d == RD) ? bin_d : rd_addr_q;
    lut_we_d   = (state_d == WR);
    lut_addr_d = (state_d == WR) ? bin_d : lut_addr_q;
    lut_data_d = (state_d == WR) ? result_d : lut_data_q;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bin_q      <= {ADDR_W{1'b0}};
      cmin_q     <= {CDF_W{1'b0}};
      ptot_q     <= {CDF_W{1'b0}};
      den_q      <= {CDF_W{1'b0}};
      rem_q      <= {CDF_W{1'b0}};
      quo_q      <= {OUT_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      result_q   <= {OUT_W{1'b0}};
      rd_en_q    <= 1'b0;
      rd_addr_q  <= {ADDR_W{1'b0}};
      lut_we_q   <= 1'b0;
      lut_addr_q <= {ADDR_W{1'b0}};
      lut_data_q <= {OUT_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      degen_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      cmin_q     <= cmin_d;
      ptot_q     <= ptot_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      lut_we_q   <= lut_we_d;
      lut_addr_q <= lut_addr_d;
      lut_data_q <= lut_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      degen_q    <= degen_d;
    end
  end

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.lut_we   = lut_we_q;
  assign bus.lut_addr = lut_addr_q;
  assign bus.lut_data = lut_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign degenerate   = degen_q;

endmodule

// File: tb/tb_cdf_lut_mapper.sv
// Scoreboard bench for cdf_lut_mapper: expected LUT writes are queued when a
// pass is launched and a monitor pops/compares on every lut_we.
module tb_cdf_lut_mapper;
  localparam int ADDR_W = 8;
  localparam int CDF_W  = 20;
  localparam int OUT_W  = 8;
  localparam int BINS   = 256;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic [CDF_W-1:0] cdf_min;
  logic [CDF_W-1:0] pixel_total;
  logic             busy, done, degenerate;

  always #5 clock = ~clock;

  cdf_lut_mapper_if #(.ADDR_W(ADDR_W), .CDF_W(CDF_W), .OUT_W(OUT_W)) bus_if ();

  cdf_lut_mapper #(.ADDR_W(ADDR_W), .CDF_W(CDF_W), .OUT_W(OUT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .cdf_min     (cdf_min),
    .pixel_total (pixel_total),
    .bus         (bus_if),
    .busy        (busy),
    .done        (done),
    .degenerate  (degenerate)
  );

  // CDF RAM model: synchronous read, one cycle latency
  logic [CDF_W-1:0] mem [BINS];
  always @(posedge clock) begin
    if (bus_if.rd_en) bus_if.rd_data <= mem[bus_if.rd_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int lat;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int model_val(int v, int cmin, int ptot, int bin);
    if (ptot <= cmin) return bin;
    if (v <= cmin) return 0;
    if (v >= ptot) return 255;
    return ((v - cmin) * 255 + (ptot - cmin) / 2) / (ptot - cmin);
  endfunction

  function automatic int model_lat(int v, int cmin, int ptot);
    if (ptot <= cmin || v <= cmin || v >= ptot) return 2;
    return 10;
  endfunction

  // Queue model expectations for a full pass; returns expected start->done cycles.
  function automatic int push_model(int cmin, int ptot);
    exp_t e;
    int len = 1;
    for (int i = 0; i < BINS; i++) begin
      e.addr = i;
      e.data = model_val(int'(mem[i]), cmin, ptot, i);
      e.lat  = model_lat(int'(mem[i]), cmin, ptot);
      exp_q.push_back(e);
      len += e.lat + 1;
    end
    return len;
  endfunction

  // Monitor: compares every LUT write against the scoreboard head
  initial begin
    int rd_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus_if.rd_en) rd_cyc = cyc;
      if (done) done_count++;
      if (bus_if.lut_we) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write addr %0d data %0d, expected no write",
                   bus_if.lut_addr, bus_if.lut_data);
        end else begin
          e = exp_q.pop_front();
          chk("lut_addr", int'(bus_if.lut_addr), e.addr);
          chk($sformatf("lut_data[%0d]", e.addr), int'(bus_if.lut_data), e.data);
          chk($sformatf("latency[%0d]", e.addr), cyc - rd_cyc, e.lat);
        end
      end
    end
  end

  int start_cyc;
  int done_cyc;

  task automatic start_pass(input int cmin, input int ptot);
    @(negedge clock);
    cdf_min     = CDF_W'(cmin);
    pixel_total = CDF_W'(ptot);
    start       = 1'b1;
    start_cyc   = cyc;
    @(negedge clock);
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        done_cyc = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
    done_cyc = cyc;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_degenerate"}, int'(degenerate), 0);
    chk({tag, "_rd_en"}, int'(bus_if.rd_en), 0);
    chk({tag, "_rd_addr"}, int'(bus_if.rd_addr), 0);
    chk({tag, "_lut_we"}, int'(bus_if.lut_we), 0);
    chk({tag, "_lut_addr"}, int'(bus_if.lut_addr), 0);
    chk({tag, "_lut_data"}, int'(bus_if.lut_data), 0);
  endtask

  task automatic pass_end_checks(input string tag, input int exp_len, input int exp_degen);
    chk({tag, "_pass_len"}, done_cyc - start_cyc, exp_len);
    chk({tag, "_degenerate"}, int'(degenerate), exp_degen);
    chk({tag, "_writes"}, wr_count, BINS);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int hv   [6] = '{5, 10, 11, 55, 100, 99};
    int hexp [6] = '{0, 0, 3, 128, 255, 252};
    int hlat [6] = '{2, 2, 10, 10, 2, 10};
    int ramp_len;
    int snap;
    bit found;
    exp_t e;

    reset_n = 1'b0;
    start = 1'b0;
    cdf_min = '0;
    pixel_total = '0;
    repeat (3) @(negedge clock);
    chk_outputs_zero("in_reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk_outputs_zero("after_reset");

    // Pass 1: hand-computed bins, pixel_total=100, cdf_min=10 (den=90)
    for (int i = 0; i < BINS; i++) mem[i] = (i < 6) ? CDF_W'(hv[i]) : CDF_W'(100);
    for (int i = 0; i < BINS; i++) begin
      e.addr = i;
      e.data = (i < 6) ? hexp[i] : 255;
      e.lat  = (i < 6) ? hlat[i] : 2;
      exp_q.push_back(e);
    end
    wr_count = 0;
    done_count = 0;
    start_pass(10, 100);
    // start while busy with different operands must be ignored
    repeat (20) @(negedge clock);
    chk("busy_mid_pass", int'(busy), 1);
    cdf_min = CDF_W'(0);
    pixel_total = CDF_W'(3);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(4000);
    pass_end_checks("p1", 793, 0);
    chk("p1_busy_on_done", int'(busy), 1);
    @(negedge clock);
    chk("p1_busy_after_done", int'(busy), 0);
    chk("p1_done_pulses", done_count, 1);

    // Pass 2: degenerate (den = 0) gives identity map; RAM holds a ramp
    for (int i = 0; i < BINS; i++) mem[i] = CDF_W'(4 * i);
    wr_count = 0;
    snap = push_model(50, 50);
    chk("degen_model_len", snap, 769);
    start_pass(50, 50);
    wait_done(4000);
    pass_end_checks("p2", 769, 1);
    // start on the done cycle is ignored
    start = 1'b1;
    cdf_min = CDF_W'(4);
    pixel_total = CDF_W'(1024);
    @(negedge clock);
    start = 1'b0;
    chk("start_on_done_ignored", int'(busy), 0);
    chk("degenerate_held", int'(degenerate), 1);
    // start one cycle after done begins a ramp pass
    wr_count = 0;
    done_count = 0;
    ramp_len = push_model(4, 1024);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
    chk("start_after_done_busy", int'(busy), 1);
    chk("degenerate_cleared", int'(degenerate), 0);
    wait_done(6000);
    pass_end_checks("p3", ramp_len, 0);
    @(negedge clock);
    chk("p3_busy_after_done", int'(busy), 0);
    chk("p3_done_pulses", done_count, 1);

    // Pass 4: asynchronous reset while dividing bin 37
    wr_count = 0;
    snap = push_model(4, 1024);
    start_pass(4, 1024);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clock);
      if (bus_if.rd_en && bus_if.rd_addr == 8'd37) found = 1'b1;
    end
    chk("found_bin37_read", int'(found), 1);
    repeat (2) @(negedge clock);      // LD, then first DIV cycle
    chk("bin37_in_div_no_we", int'(bus_if.lut_we), 0);
    #2 reset_n = 1'b0;
    #1 chk_outputs_zero("mid_reset");
    exp_q.delete();
    snap = wr_count;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("no_we_after_reset", wr_count, snap);
    chk("idle_after_reset", int'(busy), 0);

    // Fresh pass after reset restarts from bin 0
    wr_count = 0;
    ramp_len = push_model(4, 1024);
    start_pass(4, 1024);
    wait_done(6000);
    pass_end_checks("p5", ramp_len, 0);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
